// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set encodings, divider helper and FSM state types.
package uart_pkg;

   localparam int BYTE_W     = 8;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      BAUD_9600   = 3'd0,
      BAUD_19200  = 3'd1,
      BAUD_38400  = 3'd2,
      BAUD_57600  = 3'd3,
      BAUD_115200 = 3'd4
   } baud_e;

   localparam int BAUD_RATE_9600   = 9600;
   localparam int BAUD_RATE_19200  = 19200;
   localparam int BAUD_RATE_38400  = 38400;
   localparam int BAUD_RATE_57600  = 57600;
   localparam int BAUD_RATE_115200 = 115200;

   typedef enum logic [1:0] {WAIT, STORE, CHECK} word_state_e;
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;

   // clk cycles per oversample tick; never below 1 so slow clocks still tick.
   function automatic int baud_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / (OVERSAMPLE * baud);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_data_rx_if.sv
// Word-level receive bus: serial input and baud select in, assembled word and strobes out.
interface uart_data_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  uart_rx;
   logic [2:0]            baud_set;
   logic [DATA_WIDTH-1:0] data;
   logic                  rx_done;
   logic                  rx_error;
   logic                  rx_timeout;
   logic                  rx_busy;

   modport master (
      input  uart_rx, baud_set,
      output data, rx_done, rx_error, rx_timeout, rx_busy
   );

   modport slave (
      output uart_rx, baud_set,
      input  data, rx_done, rx_error, rx_timeout, rx_busy
   );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, 16x oversampling, majority vote on ticks 7/8/9.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_i,
   input  logic [2:0]        baud_set_i,
   output logic [BYTE_W-1:0] byte_data_o,
   output logic              byte_done_o,
   output logic              byte_ferr_o
);
   localparam logic [15:0] DIV_9600   = 16'(baud_div(CLK_HZ, BAUD_RATE_9600));
   localparam logic [15:0] DIV_19200  = 16'(baud_div(CLK_HZ, BAUD_RATE_19200));
   localparam logic [15:0] DIV_38400  = 16'(baud_div(CLK_HZ, BAUD_RATE_38400));
   localparam logic [15:0] DIV_57600  = 16'(baud_div(CLK_HZ, BAUD_RATE_57600));
   localparam logic [15:0] DIV_115200 = 16'(baud_div(CLK_HZ, BAUD_RATE_115200));

   byte_state_e       state_q, state_d;
   logic [1:0]        sync_q;
   logic              prev_q;
   logic [15:0]       div, div_cnt_q, div_cnt_d;
   logic [3:0]        os_cnt_q, os_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [1:0]        vote_q, vote_d;
   logic [BYTE_W-1:0] shift_q, shift_d, byte_q, byte_d;
   logic              done_q, done_d, ferr_q, ferr_d;
   logic              rx_s, tick, fall, bit_v;

   always_comb begin
      unique case (baud_set_i)
         BAUD_19200:  div = DIV_19200;
         BAUD_38400:  div = DIV_38400;
         BAUD_57600:  div = DIV_57600;
         BAUD_115200: div = DIV_115200;
         default:     div = DIV_9600;
      endcase
   end

   assign rx_s  = sync_q[1];
   assign fall  = prev_q & ~rx_s;
   assign tick  = (div_cnt_q == div - 16'd1);
   assign bit_v = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
      os_cnt_d  = os_cnt_q;
      bit_idx_d = bit_idx_q;
      vote_d    = vote_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;

      if (state_q == B_IDLE) begin
         // Re-phase the tick divider on the start edge so ticks line up with bit centres.
         div_cnt_d = '0;
         os_cnt_d  = '0;
         if (fall) state_d = B_START;
      end else if (tick) begin
         os_cnt_d = os_cnt_q + 4'd1;
         if (os_cnt_q == 4'd7) vote_d[0] = rx_s;
         if (os_cnt_q == 4'd8) vote_d[1] = rx_s;
         if (os_cnt_q == 4'd9) begin
            unique case (state_q)
               B_START: if (bit_v) state_d = B_IDLE;
               B_DATA:  shift_d = {bit_v, shift_q[BYTE_W-1:1]};
               B_STOP: begin
                  state_d = B_IDLE;
                  if (bit_v) begin
                     byte_d = shift_q;
                     done_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (os_cnt_q == 4'd15) begin
            unique case (state_q)
               B_START: begin
                  state_d   = B_DATA;
                  bit_idx_d = '0;
               end
               B_DATA: begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_d = B_STOP;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= B_IDLE;
         sync_q    <= 2'b11;
         prev_q    <= 1'b1;
         div_cnt_q <= '0;
         os_cnt_q  <= '0;
         bit_idx_q <= '0;
         vote_q    <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], rx_i};
         prev_q    <= rx_s;
         div_cnt_q <= div_cnt_d;
         os_cnt_q  <= os_cnt_d;
         bit_idx_q <= bit_idx_d;
         vote_q    <= vote_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   assign byte_data_o = byte_q;
   assign byte_done_o = done_q;
   assign byte_ferr_o = ferr_q;

endmodule

// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: packs DATA_WIDTH/8 consecutive 8N1 bytes into one word.
// Inter-byte timeout is compiled in only when UART_DATA_RX_TIMEOUT_EN is defined.
module uart_data_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int CLK_HZ         = 50_000_000
) (
   input logic            clk,
   input logic            reset,
   uart_data_rx_if.master bus
);
   logic [BYTE_W-1:0]     byte_data;
   logic                  byte_done, byte_ferr;

   word_state_e           state_q, state_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d, data_q, data_d, sr_shift;
   logic                  done_q, done_d, err_q, err_d;

   uart_byte_rx #(.CLK_HZ(CLK_HZ)) u_byte (
      .clk         (clk),
      .reset       (reset),
      .rx_i        (bus.uart_rx),
      .baud_set_i  (bus.baud_set),
      .byte_data_o (byte_data),
      .byte_done_o (byte_done),
      .byte_ferr_o (byte_ferr)
   );

   generate
      if (DATA_WIDTH == BYTE_W) begin : g_w8
         assign sr_shift = byte_data;
      end else if (MSB_FIRST != 0) begin : g_msb
         assign sr_shift = {sr_q[DATA_WIDTH-BYTE_W-1:0], byte_data};
      end else begin : g_lsb
         assign sr_shift = {byte_data, sr_q[DATA_WIDTH-1:BYTE_W]};
      end
   endgenerate

`ifdef UART_DATA_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          tmo_q, tmo_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         WAIT: begin
            if (byte_done) begin
               state_d = STORE;
            end else if (byte_ferr) begin
               cnt_d = '0;
               err_d = 1'b1;
            end
         end
         STORE: begin
            sr_d    = sr_shift;
            cnt_d   = cnt_q + 9'(BYTE_W);
            state_d = CHECK;
         end
         CHECK: begin
            if (cnt_q >= 9'(DATA_WIDTH)) begin
               data_d = sr_q;
               done_d = 1'b1;
               cnt_d  = '0;
            end
            state_d = WAIT;
         end
         default: state_d = WAIT;
      endcase

`ifdef UART_DATA_RX_TIMEOUT_EN
      timer_d = timer_q;
      tmo_d   = 1'b0;
      // A byte landing in the expiry cycle wins: the timer restarts instead of discarding.
      if (byte_done) begin
         timer_d = '0;
      end else if (state_q == WAIT && cnt_q != '0) begin
         if (timer_q == TW'(TIMEOUT_CYCLES)) begin
            timer_d = '0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WAIT;
         cnt_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef UART_DATA_RX_TIMEOUT_EN
         timer_q <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef UART_DATA_RX_TIMEOUT_EN
         timer_q <= timer_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign bus.data     = data_q;
   assign bus.rx_done  = done_q;
   assign bus.rx_error = err_q;
   assign bus.rx_busy  = (cnt_q != '0) || (state_q != WAIT);
`ifdef UART_DATA_RX_TIMEOUT_EN
   assign bus.rx_timeout = tmo_q;
`else
   assign bus.rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_data_rx.sv
// Bench for uart_data_rx: 32-bit MSB-first, 32-bit LSB-first (shared line) and 8-bit instances.
`timescale 1ns/1ps
module tb_uart_data_rx;
   import uart_pkg::*;

   localparam int CLK_HZ  = 7_372_800;   // 4 clk per oversample tick at 115200
   localparam int BIT_CYC = 64;
   localparam int TMO     = 1000;

   typedef logic [31:0] word_t;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic line_a = 1'b1;
   logic line_b = 1'b1;

   always #5 clk = ~clk;

   uart_data_rx_if #(.DATA_WIDTH(32)) if_msb ();
   uart_data_rx_if #(.DATA_WIDTH(32)) if_lsb ();
   uart_data_rx_if #(.DATA_WIDTH(8))  if_w8  ();

   assign if_msb.uart_rx  = line_a;
   assign if_lsb.uart_rx  = line_a;
   assign if_w8.uart_rx   = line_b;
   assign if_msb.baud_set = 3'(BAUD_115200);
   assign if_lsb.baud_set = 3'(BAUD_115200);
   assign if_w8.baud_set  = 3'(BAUD_115200);

   uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO), .CLK_HZ(CLK_HZ)) u_msb (
      .clk(clk), .reset(reset), .bus(if_msb));
   uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(0), .TIMEOUT_CYCLES(TMO), .CLK_HZ(CLK_HZ)) u_lsb (
      .clk(clk), .reset(reset), .bus(if_lsb));
   uart_data_rx #(.DATA_WIDTH(8), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO), .CLK_HZ(CLK_HZ)) u_w8 (
      .clk(clk), .reset(reset), .bus(if_w8));

   // Monitor: captures completed words and pulse events; only this block writes these.
   int unsigned cyc = 0;
   int unsigned bd_cyc = 0;
   int unsigned tmo_cyc = 0;
   word_t       got_q[3][$];
   int          lat_q[$];
   int          err_cnt[2] = '{0, 0};
   int          tmo_cnt[2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_msb.u_byte.byte_done_o) bd_cyc <= cyc;
      if (if_msb.rx_done) begin
         got_q[0].push_back(if_msb.data);
         lat_q.push_back(int'(cyc - bd_cyc));
      end
      if (if_lsb.rx_done) got_q[1].push_back(if_lsb.data);
      if (if_w8.rx_done)  got_q[2].push_back(word_t'(if_w8.data));
      if (if_msb.rx_error) err_cnt[0] <= err_cnt[0] + 1;
      if (if_lsb.rx_error) err_cnt[1] <= err_cnt[1] + 1;
      if (if_msb.rx_timeout) begin
         tmo_cnt[0] <= tmo_cnt[0] + 1;
         tmo_cyc    <= cyc;
      end
      if (if_lsb.rx_timeout) tmo_cnt[1] <= tmo_cnt[1] + 1;
   end

   int    checks = 0;
   int    failures = 0;
   word_t exp_q[3][$];
   int    rd[3] = '{0, 0, 0};
   int    rd_lat = 0;
   string names[3] = '{"msb", "lsb", "w8"};

   function automatic logic [35:0] outs(input int k);
      case (k)
         0:       return {if_msb.data, if_msb.rx_done, if_msb.rx_error, if_msb.rx_timeout, if_msb.rx_busy};
         1:       return {if_lsb.data, if_lsb.rx_done, if_lsb.rx_error, if_lsb.rx_timeout, if_lsb.rx_busy};
         default: return {24'h0, if_w8.data, if_w8.rx_done, if_w8.rx_error, if_w8.rx_timeout, if_w8.rx_busy};
      endcase
   endfunction

   task automatic drive(input bit sel_b, input logic v);
      if (sel_b) line_b = v;
      else       line_a = v;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit sel_b, input int idle);
      drive(sel_b, 1'b0);
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel_b, b[i]);
         repeat (BIT_CYC) @(negedge clk);
      end
      drive(sel_b, stop_bit);
      repeat (BIT_CYC) @(negedge clk);
      drive(sel_b, 1'b1);
      repeat (idle) @(negedge clk);
   endtask

   // Sends w high byte first on line A; both 32-bit scoreboards get their expected word.
   task automatic send_word(input word_t w, input int idle);
      exp_q[0].push_back(w);
      exp_q[1].push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1, 1'b0, idle);
   endtask

   task automatic score();
      word_t want;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         while (exp_q[k].size() > 0) begin
            want = exp_q[k].pop_front();
            checks++;
            if (rd[k] >= got_q[k].size()) begin
               failures++;
               $display("FAIL %s_word: no rx_done seen, expected %08h", names[k], want);
            end else begin
               if (got_q[k][rd[k]] !== want) begin
                  failures++;
                  $display("FAIL %s_word: got %08h expected %08h", names[k], got_q[k][rd[k]], want);
               end
               rd[k]++;
            end
         end
         checks++;
         if (got_q[k].size() != rd[k]) begin
            failures++;
            $display("FAIL %s_extra: %0d unexpected rx_done, expected 0", names[k], got_q[k].size() - rd[k]);
            rd[k] = got_q[k].size();
         end
      end
      while (rd_lat < lat_q.size()) begin
         checks++;
         if (lat_q[rd_lat] != 3) begin
            failures++;
            $display("FAIL done_latency: got %0d cycles expected 3", lat_q[rd_lat]);
         end
         rd_lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (outs(k) !== 36'h0) begin
            failures++;
            $display("FAIL reset_%s: got %09h expected 0", names[k], outs(k));
         end
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (outs(k) !== 36'h0) begin
            failures++;
            $display("FAIL post_reset_%s: got %09h expected 0", names[k], outs(k));
         end
      end
   endtask

   task automatic test_byte_order();
      send_word(32'h12345678, 16);
      score();
   endtask

   task automatic test_frame_error();
      int e0, e1;
      e0 = err_cnt[0];
      e1 = err_cnt[1];
      send_byte(8'h11, 1'b1, 1'b0, 16);
      send_byte(8'h22, 1'b0, 1'b0, 16);
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt[0] != e0 + 1) begin
         failures++;
         $display("FAIL rx_error_msb: got %0d pulse cycles expected 1", err_cnt[0] - e0);
      end
      checks++;
      if (err_cnt[1] != e1 + 1) begin
         failures++;
         $display("FAIL rx_error_lsb: got %0d pulse cycles expected 1", err_cnt[1] - e1);
      end
      checks++;
      if (if_msb.rx_busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_error: got %b expected 0", if_msb.rx_busy);
      end
      score();
      send_word(32'hAABBCCDD, 16);
      score();
   endtask

   task automatic test_back_to_back();
      send_word(32'h01234567, 0);
      send_word(32'h89ABCDEF, 0);
      score();
   endtask

   task automatic test_timeout();
      int t0, t1;
      t0 = tmo_cnt[0];
      t1 = tmo_cnt[1];
      send_byte(8'hA1, 1'b1, 1'b0, 16);
      send_byte(8'hB2, 1'b1, 1'b0, 16);
      checks++;
      if (if_msb.rx_busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_partial: got %b expected 1", if_msb.rx_busy);
      end
`ifdef UART_DATA_RX_TIMEOUT_EN
      for (int i = 0; i < 1500 && tmo_cnt[0] == t0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (tmo_cnt[0] != t0 + 1) begin
         failures++;
         $display("FAIL rx_timeout_msb: got %0d pulse cycles expected 1", tmo_cnt[0] - t0);
      end
      checks++;
      if (tmo_cnt[1] != t1 + 1) begin
         failures++;
         $display("FAIL rx_timeout_lsb: got %0d pulse cycles expected 1", tmo_cnt[1] - t1);
      end
      checks++;
      if (int'(tmo_cyc - bd_cyc) < TMO || int'(tmo_cyc - bd_cyc) > TMO + 10) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", tmo_cyc - bd_cyc, TMO, TMO + 10);
      end
      checks++;
      if (if_msb.rx_busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_timeout: got %b expected 0", if_msb.rx_busy);
      end
      score();
      send_word(32'h01020304, 16);
      score();
`else
      repeat (1500) @(negedge clk);
      checks++;
      if (tmo_cnt[0] != t0 || tmo_cnt[1] != t1) begin
         failures++;
         $display("FAIL no_timeout: got %0d/%0d pulses expected 0", tmo_cnt[0] - t0, tmo_cnt[1] - t1);
      end
      checks++;
      if (if_msb.rx_busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_held: got %b expected 1", if_msb.rx_busy);
      end
      exp_q[0].push_back(32'hA1B2C3D4);
      exp_q[1].push_back(32'hD4C3B2A1);
      send_byte(8'hC3, 1'b1, 1'b0, 16);
      send_byte(8'hD4, 1'b1, 1'b0, 16);
      score();
`endif
   endtask

   task automatic test_width8();
      exp_q[2].push_back(32'h55);
      send_byte(8'h55, 1'b1, 1'b1, 16);
      exp_q[2].push_back(32'hA5);
      send_byte(8'hA5, 1'b1, 1'b1, 16);
      score();
   endtask

   task automatic test_reset_mid_word();
      send_byte(8'h10, 1'b1, 1'b0, 16);
      send_byte(8'h20, 1'b1, 1'b0, 16);
      send_byte(8'h30, 1'b1, 1'b0, 16);
      checks++;
      if (if_msb.rx_busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_before_reset: got %b expected 1", if_msb.rx_busy);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (outs(k) !== 36'h0) begin
            failures++;
            $display("FAIL mid_reset_%s: got %09h expected 0", names[k], outs(k));
         end
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      send_word(32'hDEADBEEF, 16);
      score();
   endtask

   initial begin
      test_reset();
      test_byte_order();
      test_frame_error();
      test_back_to_back();
      test_timeout();
      test_width8();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_data_rx.md
# uart_data_rx

Multi-byte UART receiver that assembles `DATA_WIDTH` bits from consecutive 8N1 bytes on `uart_rx` and presents them as one word with a single-cycle `rx_done` strobe. It is the receive-side counterpart of the multi-byte transmit path: same framing, same `baud_set` encoding, same byte order option. It sits between the board-level serial input and the user logic that consumes command or data words.

## Interface

- `DATA_WIDTH`, 8: word width in bits. Must be a multiple of 8, range 8..256.
- `MSB_FIRST`, 1: 1 means the first received byte lands in `data[DATA_WIDTH-1 -: 8]`; 0 means it lands in `data[7:0]`.
- `TIMEOUT_CYCLES`, 500000: inter-byte timeout in clk cycles. Used only when the timeout feature is compiled in.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `uart_rx`  in  1  serial input, idle high. Synchronised inside the sub-module.
- `baud_set`  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7 fall back to 9600.
- `data`  out  `DATA_WIDTH`  last completed word. Held until the next completion.
- `rx_done`  out  1  one-cycle pulse; `data` is valid in the same cycle.
- `rx_error`  out  1  one-cycle pulse on a byte frame error; the partial word is discarded.
- `rx_timeout`  out  1  one-cycle pulse when a partial word is discarded by timeout.
- `rx_busy`  out  1  high while a partial word is held (`cnt != 0`) or the FSM is not in WAIT.

## Operation

- Byte layer: `uart_byte_rx` drives `byte_data[7:0]`, a `byte_done` pulse and a `byte_ferr` pulse (stop bit sampled low). `byte_data` holds stable until the next byte.
- Registers:
  - `sr[DATA_WIDTH-1:0]` shift register.
  - `cnt[8:0]` counts bits collected, in steps of 8.
  - `state[1:0]`.
- FSM states and transitions:
  - WAIT: on `byte_done`, go to STORE. On `byte_ferr`, set `cnt`<=0, pulse `rx_error`, stay in WAIT.
  - STORE: shift in `byte_data` and set `cnt`<=`cnt`+8, then go to CHECK.
    - With `MSB_FIRST`=1: `sr` <= {`sr[DATA_WIDTH-9:0]`, `byte_data`}.
    - With `MSB_FIRST`=0: `sr` <= {`byte_data`, `sr[DATA_WIDTH-1:8]`}.
    - When `DATA_WIDTH`=8, `sr` <= `byte_data` directly, with no slicing.
  - CHECK: if `cnt` >= `DATA_WIDTH`, load `data`<=`sr`, pulse `rx_done`, set `cnt`<=0. In both cases go to WAIT.
- `byte_done` and `byte_ferr` are physically at least 10 bit times apart. A pulse that arrives in STORE or CHECK cannot occur and needs no handling.
- `sr` is not cleared on discard. Stale bits are shifted out fully by the next complete word.

## Timing

- Reset values:
  - `data` = 0, `rx_done` = 0, `rx_error` = 0, `rx_timeout` = 0, `rx_busy` = 0.
  - `state` = WAIT, `cnt` = 0, `sr` = 0, timer = 0.
- Latency: `byte_done` of the last byte at cycle T gives `data`/`rx_done` at T+3.
- Latency: `byte_ferr` at cycle T gives `rx_error` at T+1.
- Every pulse output is exactly one cycle wide. There is no back-pressure; the consumer must sample on `rx_done`.
- Reset mid-word: the partial word is lost, all outputs return to their reset values, and the next byte starts a new word.
- Back-to-back words with no idle between them are supported. The 3-cycle processing is far shorter than one byte time.

## Configuration

- `UART_DATA_RX_TIMEOUT_EN` defined:
  - A timer counts clk cycles while in WAIT with `cnt != 0`. It clears on every `byte_done`.
  - When the timer reaches `TIMEOUT_CYCLES`: `cnt`<=0 and timer<=0, and `rx_timeout` pulses on the next cycle.
  - If `byte_done` arrives in the same cycle the timer expires, the byte wins and no timeout occurs.
- `UART_DATA_RX_TIMEOUT_EN` undefined:
  - No timer is built. A partial word is held indefinitely.
  - The `rx_timeout` port remains and is tied to 0.

## Structure

- Shared package `uart_pkg`:
  - `baud_set` encodings and the per-baud divider constants, shared with the transmit path.
  - `BYTE_W` = 8.
  - FSM state localparams WAIT, STORE, CHECK.
- One sub-module: `uart_byte_rx`. It covers 8N1 reception, 16x oversampling, a 2-flop input synchroniser, majority-vote sampling and the frame error flag.

## Test plan

- `DATA_WIDTH`=32, `MSB_FIRST`=1, 115200 baud, bytes 0x12,0x34,0x56,0x78 -> `data`=0x12345678, one `rx_done` pulse 3 cycles after the 4th `byte_done`.
- Same bytes with `MSB_FIRST`=0 -> `data`=0x78563412.
- Second byte sent with stop bit 0 -> `rx_error` pulse and no `rx_done`. Then bytes 0xAA,0xBB,0xCC,0xDD -> `data`=0xAABBCCDD.
- Macro on, `TIMEOUT_CYCLES`=1000: 2 bytes then idle -> `rx_timeout` pulse about 1001 cycles after the 2nd `byte_done`. Next 4 bytes 0x01..0x04 -> `data`=0x01020304. Macro off: no pulse, and a word completes after 2 more bytes.
- `reset` asserted after 3 of 4 bytes -> all outputs 0. After release, bytes 0xDE,0xAD,0xBE,0xEF -> `data`=0xDEADBEEF.
- `DATA_WIDTH`=8: bytes 0x55,0xA5 -> two `rx_done` pulses, `data`=0x55 then 0xA5.
